id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
Parametrised successor to the combinational decode stage. It decodes one RV32I-subset instruction per cycle into register indices, an immediate and control fields, and holds them in an ID/EX pipeline register. It uses valid/ready handshakes on both sides, detects load-use hazards against the instruction it currently holds and inserts a bubble, supports a synchronous flush for branch/jump redirects, and counts inserted stalls. It sits between the IF stage and the EX stage.

Parameters:
XLEN, 32, width of PC and immediate datapath
REG_ADDR_W, 5, register index width (instruction fields are truncated/zero-extended to this width)
HAZARD_EN, 1, 1 enables load-use bubble insertion; 0 disables it (in_ready ignores hazards)
STALL_CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous; discard held and incoming instruction
in_valid  in  1  IF presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
in_instruction  in  32  raw instruction
in_pc  in  XLEN  PC of instruction
out_valid  out  1  pipeline register holds a valid instruction
out_ready  in  1  EX consumes the held instruction this cycle
out_pc  out  XLEN  registered PC
out_reg_a / out_reg_b / out_reg_d  out  REG_ADDR_W each  rs1 / rs2 / rd
out_imm  out  XLEN  sign-extended immediate (I/S/B/J formats)
out_alu_operation  out  1  ALU instruction (R or I-ALU)
out_alu_operation_type  out  4  {funct7[5],funct3} for R and SRAI/SRLI; {0,funct3} for other I-ALU
out_write_register  out  1  writes rd (R, I-ALU, LOAD, JAL)
out_load_word_memory  out  1  LOAD
out_store_word_memory  out  1  STORE
out_branch  out  1  BRANCH
out_branch_operation_type  out  4  {0,funct3} for BRANCH, else 0
out_jump  out  1  JAL
out_panic  out  1  unsupported opcode
stall_count  out  STALL_CNT_W  number of bubbles inserted, saturating

Behaviour:
- Reset (reset=0, asynchronous): out_valid=0, all out_* fields=0, stall_count=0. in_ready becomes 1 once reset is deasserted. Reset mid-stream drops the held instruction.
- Opcodes: R=0110011, I-ALU=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111.
  - Any other opcode sets panic=1 and forces all write/memory/branch/jump/alu flags to 0. The instruction is still passed through with out_valid=1.
- Operand usage:
  - rs1 is used by R, I-ALU, LOAD, STORE and BRANCH.
  - rs2 is used by R, STORE and BRANCH.
- Hazard: hazard = HAZARD_EN && out_valid && out_load_word_memory && out_reg_d!=0 && in_valid && (incoming rs1==out_reg_d with rs1 used, or incoming rs2==out_reg_d with rs2 used).
- Ready: in_ready = !flush && !hazard && (!out_valid || out_ready).
- Register update, in priority order:
  - flush: out_valid<=0 next cycle; the incoming instruction is dropped.
  - else if in_valid && in_ready: load the decoded instruction; out_valid<=1.
  - else if out_ready: out_valid<=0. This is the bubble when a hazard is active.
  - else: hold all outputs unchanged.
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 instruction/cycle with no hazard and out_ready=1.
- stall_count increments on every cycle where hazard && out_ready && !flush, and saturates at all-ones.
- Outputs are stable while out_valid && !out_ready.
- out_* data fields are don't-care when out_valid=0, except after reset, where they are 0.

Test Plan:
- Reset, then drive 0xFFF00093 (addi x1,x0,-1) at PC 0x100 with out_ready=1 -> next cycle: out_valid=1, reg_d=1, reg_a=0, imm=0xFFFFFFFF, alu_operation=1, alu_operation_type=0, write_register=1, pc=0x100.
- Back-to-back 0x002081B3 (add x3,x1,x2) and 0x00110193 (addi x3,x2,1) with out_ready=1 -> in_ready stays 1; outputs appear on consecutive cycles; stall_count=0.
- 0x0000A283 (lw x5,0(x1)) followed by 0x00128333 (add x6,x5,x1) -> in_ready=0 for one cycle, one bubble (out_valid=0), add emitted next with reg_a=5, reg_b=1; stall_count=1. Same sequence with HAZARD_EN=0 -> no bubble.
- lw x0 followed by a consumer of x0 -> no stall. Hold out_ready=0 for 3 cycles with lw held -> outputs stable, stall_count unchanged.
- flush asserted while holding an instruction and in_valid=1 -> out_valid=0 next cycle, incoming instruction dropped, in_ready=0 during the flush cycle.
- 0xFFFFFFFF -> out_panic=1, write_register=0, out_valid=1. Assert reset mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: RV32I-subset decode with an ID/EX pipeline register,
// valid/ready handshakes, load-use bubble insertion, flush and a stall counter.
`default_nettype none

module id_stage_pipelined #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int HAZARD_EN   = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instruction,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [REG_ADDR_W-1:0]  out_reg_a,
  output logic [REG_ADDR_W-1:0]  out_reg_b,
  output logic [REG_ADDR_W-1:0]  out_reg_d,
  output logic [XLEN-1:0]        out_imm,
  output logic                   out_alu_operation,
  output logic [3:0]             out_alu_operation_type,
  output logic                   out_write_register,
  output logic                   out_load_word_memory,
  output logic                   out_store_word_memory,
  output logic                   out_branch,
  output logic [3:0]             out_branch_operation_type,
  output logic                   out_jump,
  output logic                   out_panic,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] ra;
    logic [REG_ADDR_W-1:0] rb;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       imm;
    logic                  alu;
    logic [3:0]            alu_type;
    logic                  wr;
    logic                  ld;
    logic                  st;
    logic                  br;
    logic [3:0]            br_type;
    logic                  jmp;
    logic                  panic;
  } payload_t;

  payload_t               payload_d;
  payload_t               payload_q;
  logic                   valid_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   use_rs1;
  logic                   use_rs2;
  logic                   hazard;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_b5;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;

  assign opcode    = in_instruction[6:0];
  assign funct3    = in_instruction[14:12];
  assign funct7_b5 = in_instruction[30];
  assign imm_i = {{(XLEN-12){in_instruction[31]}}, in_instruction[31:20]};
  assign imm_s = {{(XLEN-12){in_instruction[31]}}, in_instruction[31:25], in_instruction[11:7]};
  assign imm_b = {{(XLEN-13){in_instruction[31]}}, in_instruction[31], in_instruction[7],
                  in_instruction[30:25], in_instruction[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){in_instruction[31]}}, in_instruction[31], in_instruction[19:12],
                  in_instruction[20], in_instruction[30:21], 1'b0};

  always_comb begin
    payload_d    = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    payload_d.pc = in_pc;
    payload_d.ra = REG_ADDR_W'(in_instruction[19:15]);
    payload_d.rb = REG_ADDR_W'(in_instruction[24:20]);
    payload_d.rd = REG_ADDR_W'(in_instruction[11:7]);
    case (opcode)
      c_OP_R: begin
        payload_d.alu      = 1'b1;
        payload_d.alu_type = {funct7_b5, funct3};
        payload_d.wr       = 1'b1;
        use_rs1            = 1'b1;
        use_rs2            = 1'b1;
      end
      c_OP_I_ALU: begin
        // Only the right shifts carry funct7[5] (SRAI vs SRLI) in the I form.
        payload_d.alu      = 1'b1;
        payload_d.alu_type = (funct3 == 3'b101) ? {funct7_b5, funct3} : {1'b0, funct3};
        payload_d.wr       = 1'b1;
        payload_d.imm      = imm_i;
        use_rs1            = 1'b1;
      end
      c_OP_LOAD: begin
        payload_d.ld  = 1'b1;
        payload_d.wr  = 1'b1;
        payload_d.imm = imm_i;
        use_rs1       = 1'b1;
      end
      c_OP_STORE: begin
        payload_d.st  = 1'b1;
        payload_d.imm = imm_s;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
      end
      c_OP_BRANCH: begin
        payload_d.br      = 1'b1;
        payload_d.br_type = {1'b0, funct3};
        payload_d.imm     = imm_b;
        use_rs1           = 1'b1;
        use_rs2           = 1'b1;
      end
      c_OP_JAL: begin
        payload_d.jmp = 1'b1;
        payload_d.wr  = 1'b1;
        payload_d.imm = imm_j;
      end
      default: payload_d.panic = 1'b1;
    endcase
  end

  // Load-use hazard: the held load's result is not yet available to the incoming consumer.
  assign hazard = (HAZARD_EN != 0) && valid_q && payload_q.ld && (payload_q.rd != '0) && in_valid &&
                  ((use_rs1 && (payload_d.ra == payload_q.rd)) ||
                   (use_rs2 && (payload_d.rb == payload_q.rd)));

  assign in_ready = !flush && !hazard && (!valid_q || out_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q   <= 1'b1;
      payload_q <= payload_d;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (hazard && out_ready && !flush && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_CNT_W'(1);
    end
  end

  assign out_valid                 = valid_q;
  assign out_pc                    = payload_q.pc;
  assign out_reg_a                 = payload_q.ra;
  assign out_reg_b                 = payload_q.rb;
  assign out_reg_d                 = payload_q.rd;
  assign out_imm                   = payload_q.imm;
  assign out_alu_operation         = payload_q.alu;
  assign out_alu_operation_type    = payload_q.alu_type;
  assign out_write_register        = payload_q.wr;
  assign out_load_word_memory      = payload_q.ld;
  assign out_store_word_memory     = payload_q.st;
  assign out_branch                = payload_q.br;
  assign out_branch_operation_type = payload_q.br_type;
  assign out_jump                  = payload_q.jmp;
  assign out_panic                 = payload_q.panic;
  assign stall_count               = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_pipelined.sv
// Directed scoreboard bench for id_stage_pipelined; a second instance runs with HAZARD_EN=0.
`default_nettype none

module tb_id_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instruction = 32'd0;
  logic [31:0] in_pc = 32'd0;

  logic        in_ready, out_valid, out_alu_operation, out_write_register;
  logic        out_load_word_memory, out_store_word_memory, out_branch, out_jump, out_panic;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_reg_a, out_reg_b, out_reg_d;
  logic [3:0]  out_alu_operation_type, out_branch_operation_type;
  logic [15:0] stall_count;

  logic        n_in_ready, n_out_valid, n_alu, n_wr, n_ld, n_st, n_br, n_jmp, n_panic;
  logic [31:0] n_pc, n_imm;
  logic [4:0]  n_reg_a, n_reg_b, n_reg_d;
  logic [3:0]  n_alu_type, n_br_type;
  logic [15:0] n_stall;

  always #5 clk = ~clk;

  id_stage_pipelined u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_reg_a(out_reg_a), .out_reg_b(out_reg_b), .out_reg_d(out_reg_d), .out_imm(out_imm),
    .out_alu_operation(out_alu_operation), .out_alu_operation_type(out_alu_operation_type),
    .out_write_register(out_write_register), .out_load_word_memory(out_load_word_memory),
    .out_store_word_memory(out_store_word_memory), .out_branch(out_branch),
    .out_branch_operation_type(out_branch_operation_type), .out_jump(out_jump),
    .out_panic(out_panic), .stall_count(stall_count)
  );

  id_stage_pipelined #(.HAZARD_EN(0)) u_dut_nohz (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(n_in_ready), .in_instruction(in_instruction), .in_pc(in_pc),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_pc),
    .out_reg_a(n_reg_a), .out_reg_b(n_reg_b), .out_reg_d(n_reg_d), .out_imm(n_imm),
    .out_alu_operation(n_alu), .out_alu_operation_type(n_alu_type),
    .out_write_register(n_wr), .out_load_word_memory(n_ld),
    .out_store_word_memory(n_st), .out_branch(n_br),
    .out_branch_operation_type(n_br_type), .out_jump(n_jmp),
    .out_panic(n_panic), .stall_count(n_stall)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  ra, rb, rd;
    logic [31:0] imm;
    logic [3:0]  at, bt;
    logic        alu, wr, ld, st, br, jmp, pan;
    logic        cra, crb, crd, cimm, cat;
  } exp_t;

  // Hand-decoded expectations; c* bits select which fields are defined for the format.
  localparam exp_t E_NONE  = '{default: 0};
  localparam exp_t E_ADDI1 = '{rd: 5'd1, imm: 32'hFFFFFFFF, alu: 1, wr: 1,
                               cra: 1, crd: 1, cimm: 1, cat: 1, default: 0};
  localparam exp_t E_ADD3  = '{ra: 5'd1, rb: 5'd2, rd: 5'd3, alu: 1, wr: 1,
                               cra: 1, crb: 1, crd: 1, cat: 1, default: 0};
  localparam exp_t E_ADDI3 = '{ra: 5'd2, rd: 5'd3, imm: 32'd1, alu: 1, wr: 1,
                               cra: 1, crd: 1, cimm: 1, cat: 1, default: 0};
  localparam exp_t E_LW5   = '{ra: 5'd1, rd: 5'd5, ld: 1, wr: 1,
                               cra: 1, crd: 1, cimm: 1, default: 0};
  localparam exp_t E_ADD6  = '{ra: 5'd5, rb: 5'd1, rd: 5'd6, alu: 1, wr: 1,
                               cra: 1, crb: 1, crd: 1, cat: 1, default: 0};
  localparam exp_t E_LW0   = '{ra: 5'd1, ld: 1, wr: 1, cra: 1, crd: 1, cimm: 1, default: 0};
  localparam exp_t E_ADD7  = '{rd: 5'd7, alu: 1, wr: 1, cra: 1, crb: 1, crd: 1, cat: 1, default: 0};
  localparam exp_t E_SW    = '{ra: 5'd1, rb: 5'd2, imm: 32'd8, st: 1,
                               cra: 1, crb: 1, cimm: 1, default: 0};
  localparam exp_t E_BNE   = '{ra: 5'd1, rb: 5'd2, imm: 32'hFFFFFFFC, br: 1, bt: 4'd1,
                               cra: 1, crb: 1, cimm: 1, default: 0};
  localparam exp_t E_JAL   = '{rd: 5'd1, imm: 32'd8, jmp: 1, wr: 1, crd: 1, cimm: 1, default: 0};
  localparam exp_t E_SRAI  = '{ra: 5'd1, rd: 5'd4, imm: 32'h403, at: 4'hD, alu: 1, wr: 1,
                               cra: 1, crd: 1, cimm: 1, cat: 1, default: 0};
  localparam exp_t E_SUB   = '{ra: 5'd1, rb: 5'd2, rd: 5'd3, at: 4'h8, alu: 1, wr: 1,
                               cra: 1, crb: 1, crd: 1, cat: 1, default: 0};
  localparam exp_t E_PANIC = '{pan: 1, default: 0};

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic rdy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input exp_t e);
    chk("out_pc", 128'(out_pc), 128'(e.pc));
    chk("flags{alu,wr,ld,st,br,jmp,panic}",
        128'({out_alu_operation, out_write_register, out_load_word_memory,
              out_store_word_memory, out_branch, out_jump, out_panic}),
        128'({e.alu, e.wr, e.ld, e.st, e.br, e.jmp, e.pan}));
    chk("branch_type", 128'(out_branch_operation_type), 128'(e.bt));
    if (e.cra)  chk("reg_a", 128'(out_reg_a), 128'(e.ra));
    if (e.crb)  chk("reg_b", 128'(out_reg_b), 128'(e.rb));
    if (e.crd)  chk("reg_d", 128'(out_reg_d), 128'(e.rd));
    if (e.cimm) chk("imm", 128'(out_imm), 128'(e.imm));
    if (e.cat)  chk("alu_type", 128'(out_alu_operation_type), 128'(e.at));
  endtask

  // One clock: drive inputs, score the consumed output, record acceptance, advance.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input exp_t e, output logic r);
    in_valid = v; in_instruction = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    r = in_ready;
    if (fl) begin
      sb.delete();
    end else if (out_valid && out_ready) begin
      chk("output_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        exp_t x;
        x = sb.pop_front();
        cmp(x);
      end
    end
    if (v && in_ready) begin
      exp_t y;
      y = e;
      y.pc = pc;
      sb.push_back(y);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #2 reset = 1'b0;
    #20;
    chk("reset_outputs_zero",
        128'({out_valid, out_pc, out_reg_a, out_reg_b, out_reg_d, out_imm, out_alu_operation,
              out_alu_operation_type, out_write_register, out_load_word_memory,
              out_store_word_memory, out_branch, out_branch_operation_type, out_jump,
              out_panic, stall_count}), 128'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("in_ready_after_reset", 128'(in_ready), 128'(1));

    // Back-to-back stream with full throughput.
    cycle(1, 32'hFFF00093, 32'h100, 1, 0, E_ADDI1, rdy); chk("rdy_addi", 128'(rdy), 128'(1));
    chk("valid_after_addi", 128'(out_valid), 128'(1));
    cycle(1, 32'h002081B3, 32'h104, 1, 0, E_ADD3, rdy);  chk("rdy_add", 128'(rdy), 128'(1));
    cycle(1, 32'h00110193, 32'h108, 1, 0, E_ADDI3, rdy); chk("rdy_addi2", 128'(rdy), 128'(1));
    cycle(1, 32'h0000A283, 32'h10C, 1, 0, E_LW5, rdy);   chk("rdy_lw", 128'(rdy), 128'(1));
    chk("stall_zero_stream", 128'(stall_count), 128'(0));

    // Load-use hazard: one bubble, then the consumer.
    cycle(1, 32'h00128333, 32'h110, 1, 0, E_ADD6, rdy); chk("rdy_hazard", 128'(rdy), 128'(0));
    chk("bubble_valid", 128'(out_valid), 128'(0));
    chk("stall_one", 128'(stall_count), 128'(1));
    chk("nohz_no_bubble", 128'(n_out_valid), 128'(1));
    chk("nohz_reg_a", 128'(n_reg_a), 128'(5));
    chk("nohz_stall", 128'(n_stall), 128'(0));
    cycle(1, 32'h00128333, 32'h110, 1, 0, E_ADD6, rdy); chk("rdy_after_bubble", 128'(rdy), 128'(1));
    cycle(0, 32'h0, 32'h0, 1, 0, E_NONE, rdy);

    // Held load under backpressure: outputs and counter frozen.
    cycle(1, 32'h0000A283, 32'h200, 1, 0, E_LW5, rdy);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h00128333, 32'h204, 0, 0, E_ADD6, rdy);
      chk("hold_rdy", 128'(rdy), 128'(0));
      chk("hold_state", 128'({out_valid, out_pc, out_reg_d, out_load_word_memory}),
          128'({1'b1, 32'h200, 5'd5, 1'b1}));
      chk("hold_stall", 128'(stall_count), 128'(1));
    end
    cycle(1, 32'h00128333, 32'h204, 1, 0, E_ADD6, rdy); chk("rdy_hazard2", 128'(rdy), 128'(0));
    cycle(1, 32'h00128333, 32'h204, 1, 0, E_ADD6, rdy);
    chk("stall_two", 128'(stall_count), 128'(2));

    // lw x0 never creates a hazard; then the remaining formats.
    cycle(1, 32'h0000A003, 32'h208, 1, 0, E_LW0, rdy);
    cycle(1, 32'h000003B3, 32'h20C, 1, 0, E_ADD7, rdy); chk("rdy_x0", 128'(rdy), 128'(1));
    cycle(1, 32'h0020A423, 32'h210, 1, 0, E_SW, rdy);
    cycle(1, 32'hFE209EE3, 32'h214, 1, 0, E_BNE, rdy);
    cycle(1, 32'h008000EF, 32'h218, 1, 0, E_JAL, rdy);
    cycle(1, 32'h4030D213, 32'h21C, 1, 0, E_SRAI, rdy);
    cycle(1, 32'h402081B3, 32'h220, 1, 0, E_SUB, rdy);
    cycle(0, 32'h0, 32'h0, 0, 0, E_NONE, rdy);
    chk("stall_still_two", 128'(stall_count), 128'(2));

    // Flush while holding SUB with a new instruction offered.
    cycle(1, 32'hFFF00093, 32'h300, 0, 1, E_ADDI1, rdy); chk("rdy_flush", 128'(rdy), 128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));

    // Unsupported opcode passes through with panic.
    cycle(1, 32'hFFFFFFFF, 32'h400, 1, 0, E_PANIC, rdy);
    chk("panic_valid", 128'(out_valid), 128'(1));
    cycle(1, 32'hFFF00093, 32'h404, 1, 0, E_ADDI1, rdy);

    // Asynchronous reset mid-stream.
    in_valid = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midreset_zero",
        128'({out_valid, out_pc, out_reg_a, out_reg_b, out_reg_d, out_imm, out_alu_operation,
              out_alu_operation_type, out_write_register, out_load_word_memory,
              out_store_word_memory, out_branch, out_branch_operation_type, out_jump,
              out_panic, stall_count}), 128'd0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    cycle(1, 32'h008000EF, 32'h500, 1, 0, E_JAL, rdy); chk("rdy_post_reset", 128'(rdy), 128'(1));
    cycle(0, 32'h0, 32'h0, 1, 0, E_NONE, rdy);
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
